saturn_debug_uart_tx: RTL and testbench

- Serial transmitter for the debug character stream that the bus controller emits as `o_char_to_send`.
- Buffers characters in a small FIFO and serialises them as 8N1 UART frames on one output pin.
- Sits directly downstream of the bus block at top level; its outputs drive the board TX pin and feed back a ready flag so the producer can stall.

---
 rtl/saturn_debug_uart_tx.sv | 206 ++++++++++++++++++++
 tb/tb_saturn_debug_uart_tx.sv | 218 +++++++++++++++++++++
 2 files changed

// File: rtl/saturn_debug_uart_tx.sv
// saturn_debug_uart_tx: buffers debug characters in a small FIFO and sends
// them as 8N1 UART frames (LSB first, idle-high line) on o_tx.
// Optional build macro SATURN_UART_CRLF_EN: a popped LF (0x0A) is expanded
// to CR (0x0D) followed by LF, sent back-to-back.
module saturn_debug_uart_tx #(
    parameter int unsigned CLKS_PER_BIT = 434,
    parameter int unsigned FIFO_ADDR_W  = 4
) (
    input  logic       i_clk,
    input  logic       i_reset,
    input  logic       i_char_valid,
    input  logic [7:0] i_char,
    output logic       o_ready,
    output logic       o_tx,
    output logic       o_busy,
    output logic       o_overflow
);

    localparam int unsigned DEPTH  = 2 ** FIFO_ADDR_W;
    localparam int unsigned BAUD_W = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;

    localparam logic [FIFO_ADDR_W:0] DEPTH_C     = DEPTH[FIFO_ADDR_W:0];
    localparam logic [BAUD_W-1:0]    BAUD_RELOAD = BAUD_W'(CLKS_PER_BIT - 1);

    typedef enum logic [1:0] {
        IDLE,
        START,
        DATA,
        STOP
    } state_t;

    // FIFO storage and bookkeeping
    logic [7:0]             mem_q [DEPTH];
    logic [FIFO_ADDR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [FIFO_ADDR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [FIFO_ADDR_W:0]   count_q, count_d;
    logic                   overflow_q, overflow_d;

    // Serialiser state
    state_t                 state_q, state_d;
    logic [7:0]             shift_q, shift_d;
    logic [BAUD_W-1:0]      baud_q, baud_d;
    logic [2:0]             bit_idx_q, bit_idx_d;
    logic                   tx_q, tx_d;

    logic                   full;
    logic                   wr_en;
    logic                   pop;
    logic                   launch;
    logic                   lf_pending;
    logic [7:0]             head;

`ifdef SATURN_UART_CRLF_EN
    logic                   lf_pending_q, lf_pending_d;
    assign lf_pending = lf_pending_q;
`else
    assign lf_pending = 1'b0;
`endif

    assign full       = (count_q == DEPTH_C);
    assign wr_en      = i_char_valid && !full;
    assign head       = mem_q[rd_ptr_q];

    assign o_ready    = !full;
    assign o_tx       = tx_q;
    assign o_overflow = overflow_q;
    assign o_busy     = (state_q != IDLE) || (count_q != '0);

    // Next-state logic for the FIFO pointers, frame FSM and line driver
    always_comb begin
        state_d    = state_q;
        shift_d    = shift_q;
        baud_d     = baud_q;
        bit_idx_d  = bit_idx_q;
        tx_d       = tx_q;
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        count_d    = count_q;
        overflow_d = overflow_q | (i_char_valid && full);
        pop        = 1'b0;
        launch     = 1'b0;
`ifdef SATURN_UART_CRLF_EN
        lf_pending_d = lf_pending_q;
`endif

        case (state_q)
            IDLE: begin
                tx_d = 1'b1;
                if (count_q != '0) begin
                    launch = 1'b1;
                    pop    = 1'b1;
                end
            end
            START: begin
                if (baud_q == '0) begin
                    tx_d      = shift_q[0];
                    baud_d    = BAUD_RELOAD;
                    bit_idx_d = '0;
                    state_d   = DATA;
                end else begin
                    baud_d = baud_q - BAUD_W'(1);
                end
            end
            DATA: begin
                if (baud_q == '0) begin
                    baud_d = BAUD_RELOAD;
                    if (bit_idx_q == 3'd7) begin
                        tx_d    = 1'b1;
                        state_d = STOP;
                    end else begin
                        shift_d   = shift_q >> 1;
                        tx_d      = shift_q[1];
                        bit_idx_d = bit_idx_q + 3'd1;
                    end
                end else begin
                    baud_d = baud_q - BAUD_W'(1);
                end
            end
            STOP: begin
                if (baud_q == '0) begin
                    if (lf_pending) begin
                        launch = 1'b1;
                    end else if (count_q != '0) begin
                        launch = 1'b1;
                        pop    = 1'b1;
                    end else begin
                        state_d = IDLE;
                    end
                end else begin
                    baud_d = baud_q - BAUD_W'(1);
                end
            end
            default: state_d = IDLE;
        endcase

        // Common frame launch: drive the start bit and load the byte to send.
        // A pending LF is sent without touching the FIFO.
        if (launch) begin
            state_d   = START;
            tx_d      = 1'b0;
            baud_d    = BAUD_RELOAD;
            bit_idx_d = '0;
            if (pop) begin
                shift_d = head;
`ifdef SATURN_UART_CRLF_EN
                if (head == 8'h0A) begin
                    shift_d      = 8'h0D;
                    lf_pending_d = 1'b1;
                end
`endif
            end else begin
                shift_d = 8'h0A;
`ifdef SATURN_UART_CRLF_EN
                lf_pending_d = 1'b0;
`endif
            end
        end

        if (wr_en) begin
            wr_ptr_d = wr_ptr_q + FIFO_ADDR_W'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + FIFO_ADDR_W'(1);
        end
        count_d = count_q + {{FIFO_ADDR_W{1'b0}}, wr_en} - {{FIFO_ADDR_W{1'b0}}, pop};
    end

    // Register update; reset abandons any frame in flight and idles the line
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            state_q    <= IDLE;
            shift_q    <= '0;
            baud_q     <= '0;
            bit_idx_q  <= '0;
            tx_q       <= 1'b1;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            overflow_q <= 1'b0;
`ifdef SATURN_UART_CRLF_EN
            lf_pending_q <= 1'b0;
`endif
        end else begin
            state_q    <= state_d;
            shift_q    <= shift_d;
            baud_q     <= baud_d;
            bit_idx_q  <= bit_idx_d;
            tx_q       <= tx_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            overflow_q <= overflow_d;
`ifdef SATURN_UART_CRLF_EN
            lf_pending_q <= lf_pending_d;
`endif
        end
    end

    // FIFO storage write; contents need no reset since count gates reads
    always_ff @(posedge i_clk) begin
        if (wr_en) begin
            mem_q[wr_ptr_q] <= i_char;
        end
    end

endmodule

// File: tb/tb_saturn_debug_uart_tx.sv
// tb_saturn_debug_uart_tx: scoreboard bench for saturn_debug_uart_tx with
// CLKS_PER_BIT=4, FIFO_ADDR_W=2. Stimulus pushes expected bytes; a monitor
// decodes each 40-cycle frame on o_tx and compares against the queue.
module tb_saturn_debug_uart_tx;

    localparam int CPB = 4;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       valid = 1'b0;
    logic [7:0] ch = 8'h00;
    logic       ready, tx, busy, ovf;

    int         tests_run = 0;
    int         tests_failed = 0;
    int         cyc = 0;
    int         frames_done = 0;
    int         last_wr_cyc = 0;
    int         frame_starts[$];
    logic [7:0] exp_q[$];

    saturn_debug_uart_tx #(
        .CLKS_PER_BIT(CPB),
        .FIFO_ADDR_W (2)
    ) dut (
        .i_clk       (clk),
        .i_reset     (rst),
        .i_char_valid(valid),
        .i_char      (ch),
        .o_ready     (ready),
        .o_tx        (tx),
        .o_busy      (busy),
        .o_overflow  (ovf)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests_run++;
        if (act !== exp) begin
            tests_failed++;
            $display("FAIL %s: got %0h required %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor: decode frames at negedge, 4 samples per bit, start..stop
    initial begin : monitor
        logic        active;
        int          k;
        int          st;
        logic [39:0] s;
        logic        shape_ok;
        logic [7:0]  b;
        active = 1'b0;
        k = 0;
        st = 0;
        s = '0;
        forever begin
            @(negedge clk);
            if (rst) begin
                active = 1'b0;
            end else if (!active) begin
                if (tx === 1'b0) begin
                    active = 1'b1;
                    s = '0;
                    k = 1;
                    st = cyc;
                end
            end else begin
                s[k] = tx;
                k++;
                if (k == 10 * CPB) begin
                    active = 1'b0;
                    shape_ok = 1'b1;
                    for (int bi = 0; bi < 10; bi++)
                        for (int j = 1; j < CPB; j++)
                            if (s[bi*CPB+j] !== s[bi*CPB]) shape_ok = 1'b0;
                    if (s[39:36] !== 4'hF) shape_ok = 1'b0;
                    for (int i = 0; i < 8; i++) b[i] = s[(i+1)*CPB];
                    check("frame_shape", {31'b0, shape_ok}, 32'd1);
                    if (exp_q.size() == 0) begin
                        tests_run++;
                        tests_failed++;
                        $display("FAIL unexpected_frame: got %02h required no frame", b);
                    end else begin
                        check("frame_byte", {24'b0, b}, {24'b0, exp_q.pop_front()});
                    end
                    frame_starts.push_back(st);
                    frames_done++;
                end
            end
        end
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic write(input logic [7:0] c, input logic exp_ready);
        check("ready_before_write", {31'b0, ready}, {31'b0, exp_ready});
        valid = 1'b1;
        ch = c;
        tick();
        last_wr_cyc = cyc;
        valid = 1'b0;
        ch = 8'h00;
    endtask

    task automatic wait_frames(input int target);
        int n;
        n = 0;
        while (frames_done < target && n < 600) begin
            @(posedge clk);
            #2;
            n++;
        end
        check("frame_timeout", {31'b0, frames_done >= target}, 32'd1);
    endtask

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed + 1);
        $fatal(1, "watchdog");
    end

    initial begin : stimulus
        int base;
        int lows;

        // Reset then idle: line high, not busy, ready, no overflow
        repeat (3) tick();
        rst = 1'b0;
        repeat (20) begin
            @(negedge clk);
            check("idle_outputs", {28'b0, tx, busy, ready, ovf}, 32'b1010);
        end
        tick();

        // Single 0x41 frame
        base = frames_done;
        exp_q.push_back(8'h41);
        write(8'h41, 1'b1);
        check("busy_after_write", {31'b0, busy}, 32'd1);
        wait_frames(base + 1);
        check("start_latency", frame_starts[base] - last_wr_cyc, 32'd1);
        check("idle_after_frame", {30'b0, tx, busy}, 32'b10);

        // Two frames back-to-back
        base = frames_done;
        exp_q.push_back(8'h55);
        exp_q.push_back(8'hAA);
        write(8'h55, 1'b1);
        write(8'hAA, 1'b1);
        wait_frames(base + 2);
        check("b2b_gap", frame_starts[base+1] - frame_starts[base], 32'd40);
        check("idle_after_pair", {30'b0, tx, busy}, 32'b10);

        // Overflow: six writes, five accepted
        base = frames_done;
        for (int i = 0; i < 5; i++) exp_q.push_back(8'h30 + 8'(i));
        for (int i = 0; i < 5; i++) write(8'h30 + 8'(i), 1'b1);
        check("no_overflow_yet", {31'b0, ovf}, 32'd0);
        write(8'h35, 1'b0);
        check("overflow_set", {31'b0, ovf}, 32'd1);
        wait_frames(base + 5);
        for (int i = 0; i < 4; i++)
            check("burst_gap", frame_starts[base+i+1] - frame_starts[base+i], 32'd40);
        repeat (50) tick();
        check("burst_frame_count", frames_done - base, 32'd5);
        check("overflow_sticky", {29'b0, ovf, busy, ready}, 32'b101);

        // Reset mid-frame abandons the frame
        base = frames_done;
        write(8'h41, 1'b1);
        repeat (15) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("reset_midframe", {28'b0, tx, busy, ready, ovf}, 32'b1010);
        lows = 0;
        repeat (60) begin
            tick();
            if (tx !== 1'b1) lows++;
        end
        check("no_frame_after_reset", frames_done - base, 32'd0);
        check("line_idle_after_reset", lows, 32'd0);

        // Line feed handling
        base = frames_done;
`ifdef SATURN_UART_CRLF_EN
        exp_q.push_back(8'h0D);
        exp_q.push_back(8'h0A);
        write(8'h0A, 1'b1);
        wait_frames(base + 2);
        check("crlf_gap", frame_starts[base+1] - frame_starts[base], 32'd40);
`else
        exp_q.push_back(8'h0A);
        write(8'h0A, 1'b1);
        wait_frames(base + 1);
`endif
        repeat (50) tick();
        check("lf_frame_count", frames_done - base,
`ifdef SATURN_UART_CRLF_EN
              32'd2);
`else
              32'd1);
`endif
        check("scoreboard_empty", exp_q.size(), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
